// File: rtl/oclib_async_req_arbiter_pkg.sv
// oclib_async_req_arbiter_pkg: shared types and helpers
// for the async request arbiter.
package oclib_async_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oclib_async_req_arbiter_rr_pick.sv
// oclib_rr_pick: combinational round-robin picker.
// Returns first set bit of eligible at or above ptr, wrapping.
module oclib_rr_pick #(
  parameter int N   = 4,
  parameter int IdW = 2
) (
  input  logic [N-1:0]   eligible,
  input  logic [IdW-1:0] ptr,
  output logic           any,
  output logic [IdW-1:0] index
);

  int idx;

  // scan from farthest to nearest so the nearest hit wins
  always_comb begin
    any   = 1'b0;
    index = '0;
    idx   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (eligible[idx[IdW-1:0]]) begin
        any   = 1'b1;
        index = idx[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/oclib_synchronizer.sv
// oclib_synchronizer: multi-flop level synchronizer bank.
// SyncCycles = 0 bypasses the flops for same-clock sources.
module oclib_synchronizer #(
  parameter int Width      = 1,
  parameter int SyncCycles = 3
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [Width-1:0] in_async,
  output logic [Width-1:0] out_sync
);

  if (SyncCycles == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ resetn;
    assign out_sync = in_async;
  end else begin : g_sync
    logic [Width-1:0] stage [SyncCycles];

    // shift the async levels through the flop chain
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        for (int k = 0; k < SyncCycles; k++) begin
          stage[k] <= '0;
        end
      end else begin
        stage[0] <= in_async;
        for (int k = 1; k < SyncCycles; k++) begin
          stage[k] <= stage[k-1];
        end
      end
    end

    assign out_sync = stage[SyncCycles-1];
  end

endmodule

// File: rtl/oclib_async_req_arbiter.sv
// oclib_async_req_arbiter: shares one resource among async requesters.
// Define OCLIB_ASYNC_REQ_ARBITER_TIMEOUT_EN for the op_done watchdog.
module oclib_async_req_arbiter
  import oclib_async_req_arbiter_pkg::*;
#(
  parameter int Requesters    = 4,
  parameter int SyncCycles    = 3,
  parameter int TimeoutCycles = 1024,
  localparam int IdW = id_width(Requesters)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [Requesters-1:0] req_async,
  output logic [Requesters-1:0] ack,
  output logic                  op_valid,
  output logic [IdW-1:0]        op_id,
  input  logic                  op_ready,
  input  logic                  op_done,
  output logic                  op_error,
  output logic                  busy
);

  arb_state_e state_q, state_d;

  logic [Requesters-1:0] req_sync;
  logic [Requesters-1:0] eligible;
  logic [Requesters-1:0] ack_q, ack_d;
  logic                  valid_q, valid_d;
  logic [IdW-1:0]        id_q, id_d;
  logic [IdW-1:0]        ptr_q, ptr_d;
  logic                  pick_any;
  logic [IdW-1:0]        pick_idx;

  oclib_synchronizer #(
    .Width      (Requesters),
    .SyncCycles (SyncCycles)
  ) u_sync (
    .clock    (clock),
    .resetn   (resetn),
    .in_async (req_async),
    .out_sync (req_sync)
  );

  assign eligible = req_sync & ~ack_q;

  oclib_rr_pick #(
    .N   (Requesters),
    .IdW (IdW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .any      (pick_any),
    .index    (pick_idx)
  );

`ifdef OCLIB_ASYNC_REQ_ARBITER_TIMEOUT_EN
  logic [31:0] timer_q, timer_d;
  logic        err_q, err_d;
  logic        timeout_hit;

  assign timeout_hit = (timer_q >= 32'(TimeoutCycles - 1));
  assign op_error    = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TimeoutCycles);
  assign op_error       = 1'b0;
`endif

  // next-state and output decode
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
`ifdef OCLIB_ASYNC_REQ_ARBITER_TIMEOUT_EN
    timer_d = timer_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          id_d    = pick_idx;
          valid_d = 1'b1;
          state_d = ISSUE;
          if (int'(pick_idx) == Requesters - 1) begin
            ptr_d = '0;
          end else begin
            ptr_d = pick_idx + 1'b1;
          end
        end
      end
      ISSUE: begin
        if (op_ready) begin
          valid_d = 1'b0;
          state_d = WAIT_DONE;
`ifdef OCLIB_ASYNC_REQ_ARBITER_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      WAIT_DONE: begin
        if (op_done) begin
          ack_d[id_q] = 1'b1;
          state_d     = RELEASE;
`ifdef OCLIB_ASYNC_REQ_ARBITER_TIMEOUT_EN
        end else if (timeout_hit) begin
          ack_d[id_q] = 1'b1;
          err_d       = 1'b1;
          state_d     = RELEASE;
        end else begin
          timer_d = timer_q + 32'd1;
`endif
        end
      end
      RELEASE: begin
        if (!req_sync[id_q]) begin
          ack_d[id_q] = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ack_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef OCLIB_ASYNC_REQ_ARBITER_TIMEOUT_EN
  // watchdog counter and error pulse
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end
`endif

  assign ack      = ack_q;
  assign op_valid = valid_q;
  assign op_id    = id_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_oclib_async_req_arbiter.sv
// tb_oclib_async_req_arbiter: directed scoreboard bench.
// Issue/ack/error events are queued and checked by a monitor.
module tb_oclib_async_req_arbiter;

  localparam int N = 4;
  localparam int EvIssue = 0;
  localparam int EvAck   = 1;
  localparam int EvErr   = 2;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic [N-1:0] req_async = '0;
  logic [N-1:0] ack;
  logic         op_valid;
  logic [1:0]   op_id;
  logic         op_ready = 1'b0;
  logic         op_done = 1'b0;
  logic         op_error;
  logic         busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t sb[$];

  oclib_async_req_arbiter #(
    .Requesters    (N),
    .SyncCycles    (3),
    .TimeoutCycles (16)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_async (req_async),
    .ack       (ack),
    .op_valid  (op_valid),
    .op_id     (op_id),
    .op_ready  (op_ready),
    .op_done   (op_done),
    .op_error  (op_error),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void expect_ev(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  task automatic mon_ev(input int k, input int v);
    ev_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL sb_unexpected: got kind %0d id %0d expected none", k, v);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val != v) begin
        fails++;
        $display("FAIL sb_event: got kind %0d id %0d expected kind %0d id %0d",
                 k, v, e.kind, e.val);
      end
    end
  endtask

  logic         prev_valid = 1'b0;
  logic [N-1:0] prev_ack = '0;

  always @(negedge clock) begin
    if (resetn) begin
      if (op_error) mon_ev(EvErr, int'(op_id));
      if (op_valid && !prev_valid) mon_ev(EvIssue, int'(op_id));
      if (ack != '0 && prev_ack == '0) begin
        chk("ack_onehot", int'($onehot(ack)), 1);
        mon_ev(EvAck, idx_of(ack));
      end
    end
    prev_valid <= op_valid;
    prev_ack   <= ack;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!op_valid && n < 40) begin
      step();
      n++;
    end
    chk(name, int'(op_valid), 1);
  endtask

  task automatic wait_ack_clear(input string name);
    int n;
    n = 0;
    while (ack != '0 && n < 40) begin
      step();
      n++;
    end
    chk(name, int'(ack), 0);
  endtask

  task automatic serve(input int dly);
    wait_valid("serve_valid");
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    repeat (dly - 1) step();
    op_done = 1'b1;
    step();
    op_done = 1'b0;
  endtask

  task automatic finish_agent(input int a);
    req_async[a] = 1'b0;
    wait_ack_clear("release_ack");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (2) step();
    chk("rst_ack", int'(ack), 0);
    chk("rst_valid", int'(op_valid), 0);
    chk("rst_id", int'(op_id), 0);
    chk("rst_err", int'(op_error), 0);
    chk("rst_busy", int'(busy), 0);
    resetn = 1'b1;
    step();

    // single request, latency and release timing
    expect_ev(EvIssue, 2);
    expect_ev(EvAck, 2);
    req_async[2] = 1'b1;
    repeat (3) step();
    chk("t1_lat_early", int'(op_valid), 0);
    step();
    chk("t1_lat_valid", int'(op_valid), 1);
    chk("t1_lat_id", int'(op_id), 2);
    chk("t1_busy", int'(busy), 1);
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    chk("t1_valid_drop", int'(op_valid), 0);
    repeat (4) step();
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    chk("t1_ack", int'(ack), 4);
    req_async[2] = 1'b0;
    repeat (3) step();
    chk("t1_ack_hold", int'(ack), 4);
    step();
    chk("t1_ack_fall", int'(ack), 0);
    chk("t1_idle", int'(busy), 0);

    // fresh pointer, all four at once
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
    for (int i = 0; i < N; i++) begin
      expect_ev(EvIssue, i);
      expect_ev(EvAck, i);
    end
    req_async = 4'b1111;
    for (int i = 0; i < N; i++) begin
      serve(2);
      finish_agent(i);
    end
    expect_ev(EvIssue, 0);
    expect_ev(EvAck, 0);
    expect_ev(EvIssue, 3);
    expect_ev(EvAck, 3);
    req_async = 4'b1001;
    serve(2);
    finish_agent(0);
    serve(2);
    finish_agent(3);

    // stalled issue, early done pulses ignored
    expect_ev(EvIssue, 1);
    expect_ev(EvAck, 1);
    req_async[1] = 1'b1;
    wait_valid("t3_valid");
    for (int c = 0; c < 10; c++) begin
      op_done = (c == 3 || c == 7);
      step();
      chk("t3_hold", int'({ack, op_valid, op_id}), int'({4'b0000, 1'b1, 2'd1}));
    end
    op_ready = 1'b1;
    op_done  = 1'b1;
    step();
    op_ready = 1'b0;
    op_done  = 1'b0;
    chk("t3_done_at_accept", int'(ack), 0);
    chk("t3_busy", int'(busy), 1);
    step();
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    chk("t3_ack", int'(ack), 2);
    finish_agent(1);

    // requester drops during WAIT_DONE
    expect_ev(EvIssue, 2);
    expect_ev(EvAck, 2);
    expect_ev(EvIssue, 0);
    expect_ev(EvAck, 0);
    req_async = 4'b0101;
    wait_valid("t4_valid");
    chk("t4_id", int'(op_id), 2);
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    req_async[2] = 1'b0;
    repeat (4) step();
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    chk("t4_ack_pulse", int'(ack), 4);
    step();
    chk("t4_ack_gone", int'(ack), 0);
    serve(2);
    finish_agent(0);

    // async reset mid-op clears everything, ptr restarts at 0
    expect_ev(EvIssue, 1);
    req_async = 4'b1010;
    wait_valid("t5_valid");
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    step();
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_rst_ack", int'(ack), 0);
    chk("t5_rst_valid", int'(op_valid), 0);
    chk("t5_rst_id", int'(op_id), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_err", int'(op_error), 0);
    expect_ev(EvIssue, 1);
    expect_ev(EvAck, 1);
    expect_ev(EvIssue, 3);
    expect_ev(EvAck, 3);
    step();
    resetn = 1'b1;
    serve(2);
    finish_agent(1);
    serve(2);
    finish_agent(3);

`ifdef OCLIB_ASYNC_REQ_ARBITER_TIMEOUT_EN
    // watchdog expiry, then done racing the watchdog
    expect_ev(EvIssue, 0);
    expect_ev(EvErr, 0);
    expect_ev(EvAck, 0);
    req_async[0] = 1'b1;
    wait_valid("t6_valid");
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    repeat (15) step();
    chk("t6_err_early", int'(op_error), 0);
    chk("t6_ack_early", int'(ack), 0);
    step();
    chk("t6_err", int'(op_error), 1);
    chk("t6_ack", int'(ack), 1);
    step();
    chk("t6_err_pulse", int'(op_error), 0);
    finish_agent(0);
    expect_ev(EvIssue, 1);
    expect_ev(EvAck, 1);
    req_async[1] = 1'b1;
    wait_valid("t6b_valid");
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    repeat (15) step();
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    chk("t6b_err", int'(op_error), 0);
    chk("t6b_ack", int'(ack), 2);
    finish_agent(1);
`else
    // no watchdog: a long wait never errors or acks
    expect_ev(EvIssue, 0);
    expect_ev(EvAck, 0);
    req_async[0] = 1'b1;
    wait_valid("t6_valid");
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    repeat (19) step();
    chk("t6_err", int'(op_error), 0);
    chk("t6_ack_wait", int'(ack), 0);
    op_done = 1'b1;
    step();
    op_done = 1'b0;
    chk("t6_ack", int'(ack), 1);
    finish_agent(0);
`endif

    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
